// File: rtl/axis_converter_lite_pkg_prm.sv
// Shared parameters and types for the converter-lite subsystem.
//
// Contents:
//   AXI_DATA_WIDTH / AXI_ADDR_WIDTH / AXI_STRB_WIDTH : bus geometry
//   ADDR_DATA, ADDR_DATA_LAST, ADDR_STATUS, ADDR_DROP_CNT : register offsets
//   RESP_OKAY, RESP_SLVERR                           : AXI response codes
//   reg_sel_e                                        : decoded addr[3:2]
//   axis_entry_t                                     : TX FIFO entry
//
// Optional feature macro: AXIL_AXIS_TKEEP_EN adds a per-entry tkeep field.
package axis_converter_lite_pkg_prm;

  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [3:0] ADDR_DATA      = 4'h0;
  localparam logic [3:0] ADDR_DATA_LAST = 4'h4;
  localparam logic [3:0] ADDR_STATUS    = 4'h8;
  localparam logic [3:0] ADDR_DROP_CNT  = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    REG_DATA      = ADDR_DATA[3:2],
    REG_DATA_LAST = ADDR_DATA_LAST[3:2],
    REG_STATUS    = ADDR_STATUS[3:2],
    REG_DROP_CNT  = ADDR_DROP_CNT[3:2]
  } reg_sel_e;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] tdata;
    logic                      tlast;
`ifdef AXIL_AXIS_TKEEP_EN
    logic [AXI_STRB_WIDTH-1:0] tkeep;
`endif
  } axis_entry_t;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle (AW/W/B/AR/R) used between the interconnect and slaves.
//
// Modport:
//   s_axil : slave view (valids/payloads in, readies/responses out)
interface axil_if;
  import axis_converter_lite_pkg_prm::*;

  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [AXI_STRB_WIDTH-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport s_axil (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a parameterised entry type.
//
// Parameters: DEPTH (power of two, >= 2), entry_t (stored type).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request (ignored while full)
//   pop, pop_data     : read request (ignored while empty); pop_data is the head
//   full, empty, level: occupancy, derived from the registered pointers
module axis_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter type entry_t = logic
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t       mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axil_axis_tx_bridge.sv
// AXI-Lite slave that turns CPU register writes into an AXI-Stream output.
//
// Register map (addr[3:2]):
//   0x0 DATA      (W) push word, tlast=0
//   0x4 DATA_LAST (W) push word, tlast=1
//   0x8 STATUS    (R) bit0 empty, bit1 full, bits[15:8] level
//   0xC DROP_CNT  (R) saturating count of pushes rejected because FIFO full
//
// Ports:
//   aclk, aresetn     : clock, asynchronous active-low reset
//   s_axil            : AXI-Lite slave (axil_if.s_axil)
//   m_axis_tdata/tvalid/tready/tlast : stream master
//   m_axis_tkeep      : byte keep, only when AXIL_AXIS_TKEEP_EN is defined
//
// Optional feature macro: AXIL_AXIS_TKEEP_EN (store wstrb as tkeep, accept
// any non-zero strobe).
module axil_axis_tx_bridge
  import axis_converter_lite_pkg_prm::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axil_if.s_axil                    s_axil,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
`ifdef AXIL_AXIS_TKEEP_EN
  ,
  output logic [AXI_STRB_WIDTH-1:0] m_axis_tkeep
`endif
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Holds the readies low during reset and the first cycle after it.
  logic                      live;

  logic                      aw_held;
  logic                      w_held;
  reg_sel_e                  aw_sel_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [AXI_STRB_WIDTH-1:0] w_strb_q;

  logic                      awready;
  logic                      wready;
  logic                      arready;
  logic                      bvalid;
  logic [1:0]                bresp;
  logic                      rvalid;
  logic [1:0]                rresp;
  logic [AXI_DATA_WIDTH-1:0] rdata;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      b_hs;
  logic                      ar_hs;
  logic                      r_hs;

  reg_sel_e                  aw_sel_cur;
  logic [AXI_DATA_WIDTH-1:0] w_data_cur;
  logic [AXI_STRB_WIDTH-1:0] w_strb_cur;
  logic                      commit;
  logic                      is_data;
  logic                      strb_ok;
  logic                      accept;
  logic                      push;
  logic                      drop;
  logic                      pop;

  logic [31:0]               drop_cnt;
  reg_sel_e                  ar_sel;
  logic [AXI_DATA_WIDTH-1:0] rd_word;

  axis_entry_t               push_entry;
  axis_entry_t               head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [LVL_W-1:0]          fifo_level;

  logic                      unused_addr_bits;

  assign unused_addr_bits = ^{s_axil.awaddr[AXI_ADDR_WIDTH-1:4], s_axil.awaddr[1:0],
                              s_axil.araddr[AXI_ADDR_WIDTH-1:4], s_axil.araddr[1:0]};

  // ---------------------------------------------------------------- handshakes
  assign awready = live && !aw_held && !bvalid;
  assign wready  = live && !w_held && !bvalid;
  assign arready = live && !rvalid;

  assign aw_hs = s_axil.awvalid && awready;
  assign w_hs  = s_axil.wvalid && wready;
  assign b_hs  = bvalid && s_axil.bready;
  assign ar_hs = s_axil.arvalid && arready;
  assign r_hs  = rvalid && s_axil.rready;

  assign s_axil.awready = awready;
  assign s_axil.wready  = wready;
  assign s_axil.arready = arready;
  assign s_axil.bvalid  = bvalid;
  assign s_axil.bresp   = bresp;
  assign s_axil.rvalid  = rvalid;
  assign s_axil.rresp   = rresp;
  assign s_axil.rdata   = rdata;

  // ---------------------------------------------------------------- write path
  // Address/data come from the live bus in the handshake cycle so that the
  // commit can happen in the same cycle as the later of the AW/W handshakes.
  assign aw_sel_cur = aw_held ? aw_sel_q : reg_sel_e'(s_axil.awaddr[3:2]);
  assign w_data_cur = w_held ? w_data_q : s_axil.wdata;
  assign w_strb_cur = w_held ? w_strb_q : s_axil.wstrb;
  assign commit     = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid;
  assign is_data    = (aw_sel_cur == REG_DATA) || (aw_sel_cur == REG_DATA_LAST);

`ifdef AXIL_AXIS_TKEEP_EN
  assign strb_ok = |w_strb_cur;
`else
  assign strb_ok = &w_strb_cur;
`endif

  assign accept = commit && is_data && strb_ok;
  assign push   = accept && !fifo_full;
  assign drop   = accept && fifo_full;

  always_comb begin
    push_entry       = '0;
    push_entry.tdata = w_data_cur;
    push_entry.tlast = (aw_sel_cur == REG_DATA_LAST);
`ifdef AXIL_AXIS_TKEEP_EN
    push_entry.tkeep = w_strb_cur;
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live     <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_sel_q <= REG_DATA;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      drop_cnt <= '0;
    end else begin
      live <= 1'b1;
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_sel_q <= reg_sel_e'(s_axil.awaddr[3:2]);
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axil.wdata;
          w_strb_q <= s_axil.wstrb;
        end
      end
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= push ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid <= 1'b0;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------- read path
  assign ar_sel = reg_sel_e'(s_axil.araddr[3:2]);

  always_comb begin
    rd_word = '0;
    case (ar_sel)
      REG_STATUS: begin
        rd_word[0]    = fifo_empty;
        rd_word[1]    = fifo_full;
        rd_word[15:8] = 8'(fifo_level);
      end
      REG_DROP_CNT: rd_word = AXI_DATA_WIDTH'(drop_cnt);
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= RESP_OKAY;
      rdata  <= rd_word;
    end else if (r_hs) begin
      rvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  assign pop = m_axis_tvalid && m_axis_tready;

  axis_sync_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (axis_entry_t)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : head.tdata;
  assign m_axis_tlast  = !fifo_empty && head.tlast;
`ifdef AXIL_AXIS_TKEEP_EN
  assign m_axis_tkeep  = fifo_empty ? '0 : head.tkeep;
`endif

endmodule

// File: tb/tb_axil_axis_tx_bridge.sv
// Directed testbench for axil_axis_tx_bridge (FIFO_DEPTH = 16).
module tb_axil_axis_tx_bridge;
  import axis_converter_lite_pkg_prm::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
`ifdef AXIL_AXIS_TKEEP_EN
  logic [3:0]  tkeep;
`endif

  axil_if bus ();

  axil_axis_tx_bridge #(.FIFO_DEPTH(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axil        (bus),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
`ifdef AXIL_AXIS_TKEEP_EN
    ,
    .m_axis_tkeep  (tkeep)
`endif
  );

  always #5 aclk = ~aclk;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_now, w_now;
    int unsigned cyc;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    while (!(aw_done && w_done) && cyc < 64) begin
      @(negedge aclk);
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      @(posedge aclk); #1;
      if (aw_now) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_now)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("wr_handshake", 32'(aw_done && w_done), 32'd1);
    cyc = 0;
    while (!bus.bvalid && cyc < 64) begin
      @(posedge aclk); #1;
      cyc++;
    end
    check("wr_bvalid", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data);
    bit ar_done, ar_now;
    int unsigned cyc;
    ar_done = 1'b0;
    cyc     = 0;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!ar_done && cyc < 64) begin
      @(negedge aclk);
      ar_now = bus.arready;
      @(posedge aclk); #1;
      if (ar_now) begin bus.arvalid = 1'b0; ar_done = 1'b1; end
      cyc++;
    end
    bus.arvalid = 1'b0;
    check("rd_handshake", 32'(ar_done), 32'd1);
    cyc = 0;
    while (!bus.rvalid && cyc < 64) begin
      @(posedge aclk); #1;
      cyc++;
    end
    check("rd_rvalid", 32'(bus.rvalid), 32'd1);
    check("rd_rresp", 32'(bus.rresp), 32'(RESP_OKAY));
    data = bus.rdata;
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int unsigned n_ok;
    logic [31:0] exp_data [3];
    logic        exp_last [3];

    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    tready = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready",  32'(bus.wready),  32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    check("rst_tvalid",  32'(tvalid),      32'd0);
    check("rst_tlast",   32'(tlast),       32'd0);
    @(negedge aclk) aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("live_awready", 32'(bus.awready), 32'd1);

    // 1: AW at cycle 0, W at cycle 3, bvalid at cycle 4
    tready = 1'b1;
    bus.awaddr = 32'h0; bus.awvalid = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    check("t1_awready_held", 32'(bus.awready), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    check("t1_no_early_b", 32'(bus.bvalid), 32'd0);
    bus.wdata = 32'hA5A5_0001; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
    check("t1_bvalid",  32'(bus.bvalid), 32'd1);
    check("t1_bresp",   32'(bus.bresp),  32'(RESP_OKAY));
    check("t1_tvalid",  32'(tvalid),     32'd1);
    check("t1_tdata",   tdata,           32'hA5A5_0001);
    check("t1_tlast",   32'(tlast),      32'd0);
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    tready = 1'b0;
    check("t1_b_done",   32'(bus.bvalid), 32'd0);
    check("t1_popped",   32'(tvalid),     32'd0);

    // 2: three words, tlast only on the DATA_LAST write
    axil_write(32'h0, 32'h1, 4'hF, resp); check("t2_resp0", 32'(resp), 32'(RESP_OKAY));
    axil_write(32'h0, 32'h2, 4'hF, resp); check("t2_resp1", 32'(resp), 32'(RESP_OKAY));
    axil_write(32'h4, 32'h3, 4'hF, resp); check("t2_resp2", 32'(resp), 32'(RESP_OKAY));
    axil_read(32'h8, rd);
    check("t2_status", rd, 32'h0000_0300);
    exp_data[0] = 32'h1; exp_last[0] = 1'b0;
    exp_data[1] = 32'h2; exp_last[1] = 1'b0;
    exp_data[2] = 32'h3; exp_last[2] = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_tvalid%0d", i), 32'(tvalid), 32'd1);
      check($sformatf("t2_tdata%0d", i),  tdata,       exp_data[i]);
      check($sformatf("t2_tlast%0d", i),  32'(tlast),  32'(exp_last[i]));
      @(posedge aclk); #1;
    end
    check("t2_drained", 32'(tvalid), 32'd0);
    tready = 1'b0;

    // 4: partial strobe, register-space writes and reads
    axil_write(32'h0, 32'hDEAD_0004, 4'b0111, resp);
`ifdef AXIL_AXIS_TKEEP_EN
    check("t4_resp",  32'(resp),   32'(RESP_OKAY));
    check("t4_tvalid", 32'(tvalid), 32'd1);
    check("t4_tkeep", 32'(tkeep),  32'h7);
    tready = 1'b1;
    @(posedge aclk); #1;
    tready = 1'b0;
    check("t4_popped", 32'(tvalid), 32'd0);
`else
    check("t4_resp",   32'(resp),   32'(RESP_SLVERR));
    check("t4_tvalid", 32'(tvalid), 32'd0);
`endif
    axil_read(32'hC, rd);
    check("t4_drop", rd, 32'd0);
    axil_write(32'h8, 32'h1234, 4'hF, resp); check("wr_status_resp", 32'(resp), 32'(RESP_SLVERR));
    axil_write(32'hC, 32'h1234, 4'hF, resp); check("wr_drop_resp",   32'(resp), 32'(RESP_SLVERR));
    check("wr_reg_no_beat", 32'(tvalid), 32'd0);
    axil_read(32'h0, rd); check("rd_data_reg", rd, 32'd0);
    axil_read(32'h4, rd); check("rd_last_reg", rd, 32'd0);
    axil_read(32'h8, rd); check("status_empty", rd, 32'h0000_0001);

    // 3: fill 16 entries, 17th rejected
    n_ok = 0;
    for (int i = 0; i < 16; i++) begin
      axil_write(32'h0, 32'h100 + 32'(i), 4'hF, resp);
      if (resp == RESP_OKAY) n_ok++;
    end
    check("t3_ok_count", n_ok, 32'd16);
    axil_write(32'h0, 32'h1FF, 4'hF, resp);
    check("t3_resp17", 32'(resp), 32'(RESP_SLVERR));
    axil_read(32'hC, rd); check("t3_drop", rd, 32'd1);
    axil_read(32'h8, rd); check("t3_status", rd, 32'h0000_1002);
    check("t3_head", tdata, 32'h100);

    // 5: commit coincides with a pop while full
    bus.awaddr = 32'h0; bus.awvalid = 1'b1;
    bus.wdata = 32'h200; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tready = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; tready = 1'b0;
    check("t5_bvalid", 32'(bus.bvalid), 32'd1);
    check("t5_bresp",  32'(bus.bresp),  32'(RESP_SLVERR));
    check("t5_head",   tdata,           32'h101);
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    axil_read(32'h8, rd); check("t5_status", rd, 32'h0000_0F00);
    axil_read(32'hC, rd); check("t5_drop",   rd, 32'd2);

    // 6: reset with a beat pending and bvalid high
    bus.awaddr = 32'h0; bus.awvalid = 1'b1;
    bus.wdata = 32'h300; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("t6_bvalid", 32'(bus.bvalid), 32'd1);
    check("t6_bresp",  32'(bus.bresp),  32'(RESP_OKAY));
    check("t6_tvalid", 32'(tvalid),     32'd1);
    aresetn = 1'b0;
    #2;
    check("t6_rst_tvalid",  32'(tvalid),      32'd0);
    check("t6_rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("t6_rst_awready", 32'(bus.awready), 32'd0);
    @(negedge aclk) aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("t6_post_tvalid", 32'(tvalid), 32'd0);
    axil_read(32'h8, rd); check("t6_status", rd, 32'h0000_0001);
    axil_read(32'hC, rd); check("t6_drop",   rd, 32'd0);
    check("t6_still_idle", 32'(tvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
